// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with traps and a retired counter.
// Latency: BRANCH 3, ALU/jump/store 4, LOAD 5 cycles, plus one cycle per mem_ready wait.
// Backpressure: mem_req held until mem_ready; 2^TIMEOUT_W-1 unanswered cycles trap to TRAP.
module multicycle_control_unit #(
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 32,
    parameter int STRICT_F7 = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [3:0]       ALU_C,
    output logic [1:0]       opA,
    output logic             opB,
    output logic [1:0]       imm_sel,
    output logic [1:0]       next_sel,
    output logic             mem_reg,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110, ALU_SLT  = 4'b0111, ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010;

    // Saturated value, and the last count before the timeout fires.
    localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               cur_state, nxt_state;
    logic [6:0]           op_q;
    logic [2:0]           f3_q;
    logic                 f7_q;
    logic [TIMEOUT_W-1:0] wait_cnt, wait_nxt;
    logic                 set_illegal, set_timeout, retire;
    logic                 op_known, f7_bad;
    logic                 is_r, is_i, is_s, is_load, is_jalr, is_branch, is_auipc, is_lui, is_jal;
    logic [3:0]           alu_dec;
    logic [1:0]           opa_dec, imm_dec;
    logic                 opb_dec;

    // Legality of the live instruction fields, consulted only in DECODE.
    always_comb begin
        unique case (opcode)
            OP_R, OP_I, OP_S, OP_LOAD, OP_JALR, OP_BRANCH,
            OP_AUIPC, OP_LUI, OP_JAL: op_known = 1'b1;
            default:                  op_known = 1'b0;
        endcase
        f7_bad = (STRICT_F7 != 0) && (opcode == OP_R) && func7 &&
                 (func3 != 3'b000) && (func3 != 3'b101);
    end

    // Instruction class from the latched opcode.
    always_comb begin
        is_r      = (op_q == OP_R);
        is_i      = (op_q == OP_I);
        is_s      = (op_q == OP_S);
        is_load   = (op_q == OP_LOAD);
        is_jalr   = (op_q == OP_JALR);
        is_branch = (op_q == OP_BRANCH);
        is_auipc  = (op_q == OP_AUIPC);
        is_lui    = (op_q == OP_LUI);
        is_jal    = (op_q == OP_JAL);
    end

    // ALU operation and datapath selects from the latched fields.
    always_comb begin
        alu_dec = ALU_ADD;
        if (is_r || is_i) begin
            unique case (f3_q)
                3'b000:  alu_dec = (is_r && f7_q) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_dec = ALU_SLL;
                3'b010:  alu_dec = ALU_SLT;
                3'b011:  alu_dec = ALU_SLTU;
                3'b100:  alu_dec = ALU_XOR;
                3'b101:  alu_dec = f7_q ? ALU_SRA : ALU_SRL;
                3'b110:  alu_dec = ALU_OR;
                default: alu_dec = ALU_AND;
            endcase
        end else if (is_lui) begin
            alu_dec = ALU_PASSB;
        end else if (is_branch) begin
            alu_dec = ALU_SUB;
        end
        opa_dec = is_jalr ? 2'b01 : (is_auipc || is_lui || is_jal) ? 2'b10 : 2'b00;
        opb_dec = is_i || is_s || is_load || is_auipc;
        imm_dec = (is_load || is_jalr) ? 2'b10 : (is_branch || is_auipc) ? 2'b01 : 2'b00;
    end

    // State, decoded fields, wait counter, sticky flags and retired count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_FETCH;
            op_q        <= '0;
            f3_q        <= '0;
            f7_q        <= 1'b0;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            timeout_err <= 1'b0;
            retired     <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            if (cur_state == S_DECODE) begin
                op_q <= opcode;
                f3_q <= func3;
                f7_q <= func7;
            end
            if (set_illegal) illegal <= 1'b1;
            if (set_timeout) timeout_err <= 1'b1;
            if (retire) retired <= retired + 1'b1;
        end
    end

    // Next state and per-state strobes; memory strobes are forced low while reset is asserted.
    always_comb begin
        nxt_state   = cur_state;
        wait_nxt    = wait_cnt;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        ALU_C       = 4'b0000;
        opA         = 2'b00;
        opB         = 1'b0;
        imm_sel     = 2'b00;
        next_sel    = 2'b00;
        mem_reg     = 1'b0;
        if (cur_state == S_EXEC || cur_state == S_MEM || cur_state == S_WB) begin
            ALU_C   = alu_dec;
            opA     = opa_dec;
            opB     = opb_dec;
            imm_sel = imm_dec;
        end
        unique case (cur_state)
            S_FETCH, S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cur_state == S_MEM) && is_s;
                if (mem_ready) begin
                    wait_nxt = '0;
                    if (cur_state == S_FETCH) begin
                        ir_write  = 1'b1;
                        nxt_state = S_DECODE;
                    end else if (is_s) begin
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                        nxt_state = S_FETCH;
                    end else begin
                        nxt_state = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_nxt    = WAIT_MAX;
                    set_timeout = 1'b1;
                    nxt_state   = S_TRAP;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                if (!op_known || f7_bad) begin
                    set_illegal = 1'b1;
                    nxt_state   = S_TRAP;
                end else begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_write  = 1'b1;
                    next_sel  = branch_taken ? 2'b11 : 2'b00;
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end else if (is_load || is_s) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                mem_reg   = is_load;
                next_sel  = is_jal ? 2'b10 : is_jalr ? 2'b01 : 2'b00;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_TRAP;
        endcase
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            ir_write = 1'b0;
        end
    end

    assign state = cur_state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised successor to the single-cycle RV32I decoder: a multi-cycle control FSM that sequences FETCH/DECODE/EXEC/MEM/WB for the RV32I base set.
- Adds a memory request/ready handshake with a timeout, illegal-instruction trapping, strict func7 checking and a retired-instruction counter.
- Sits between the instruction/data memory port and the datapath. It drives the same mux selects (opA, opB, imm_sel, next_sel, mem_reg) and the ALU_C encoding as the existing datapath.

Parameters:
- TIMEOUT_W, 4: width of the memory-wait counter; timeout fires after 2^TIMEOUT_W-1 cycles without mem_ready.
- CNT_W, 32: width of the retired-instruction counter.
- STRICT_F7, 1: when 1, R-type func7=1 with func3 not in {000,101} is illegal; when 0, those encodings decode as func7=0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0]; sampled only in DECODE
- func3  in  3  instr[14:12]; sampled in DECODE
- func7  in  1  instr[30]; sampled in DECODE
- branch_taken  in  1  comparator result; valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request (fetch or data)
- mem_we  out  1  write strobe; qualifies mem_req in MEM for stores
- ir_write  out  1  one-cycle instruction-register load strobe
- pc_write  out  1  one-cycle PC update strobe
- reg_write  out  1  register-file write strobe
- ALU_C  out  4  ALU operation
- opA  out  2  ALU A select
- opB  out  1  ALU B select
- imm_sel  out  2  immediate format select
- next_sel  out  2  next-PC select: 00 pc+4, 01 jalr, 10 jal, 11 branch target
- mem_reg  out  1  write-back from memory
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- illegal  out  1  sticky: illegal instruction trapped
- timeout_err  out  1  sticky: memory timeout trapped
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; every strobe, select, ALU_C, flag and retired = 0; wait counter = 0.
  - Reset mid-handshake drops mem_req immediately.
- Opcodes (standard RV32I): R 0110011, I 0010011, S 0100011, LOAD 0000011, JALR 1100111, BRANCH 1100011, AUIPC 0010111, LUI 0110111, JAL 1101111.
- ALU_C encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SLT 0111, SLTU 1000, SRA 1001, PASSB 1010.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_write=1 for that cycle, wait counter cleared, -> DECODE.
  - Otherwise wait counter increments; at 2^TIMEOUT_W-1 -> TRAP with timeout_err=1.
- DECODE:
  - Latch opcode/func3/func7 into internal registers. All later outputs depend only on state and the latched fields, never on live inputs.
  - Unknown opcode, or a STRICT_F7 violation -> TRAP with illegal=1. Otherwise -> EXEC.
- ALU_C decode:
  - R: func3 000 gives ADD, or SUB when func7=1.
  - R and I share: 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; 101 gives SRL, or SRA when func7=1.
  - I-type func3=000 is ADDI regardless of func7.
  - LOAD, S, AUIPC, JAL, JALR use ADD; LUI uses PASSB; BRANCH uses SUB.
- EXEC:
  - R, I, LUI, AUIPC, JAL, JALR -> WB.
  - LOAD, S -> MEM.
  - BRANCH: pc_write=1, next_sel=11 if branch_taken else 00; retired++; -> FETCH.
- MEM:
  - mem_req=1; mem_we=1 only for S. Same timeout rule as FETCH.
  - On mem_ready: S gets pc_write=1, next_sel=00, retired++, -> FETCH; LOAD -> WB.
- WB:
  - reg_write=1 and pc_write=1 for one cycle; retired++; -> FETCH.
  - mem_reg=1 only for LOAD.
  - next_sel is 10 for JAL, 01 for JALR, else 00.
- Select values per class, held from EXEC through WB:
  - R: opA=00, opB=0.
  - I: opA=00, opB=1.
  - S: opA=00, opB=1.
  - LOAD: opA=00, opB=1, imm_sel=10.
  - JALR: opA=01, imm_sel=10.
  - BRANCH: imm_sel=01.
  - AUIPC: opA=10, opB=1, imm_sel=01.
  - LUI and JAL: opA=10.
  - Unlisted selects = 0.
- TRAP: all strobes 0, mem_req=0, flags held; only reset exits.
- Counters:
  - retired wraps modulo 2^CNT_W.
  - The wait counter saturates at timeout and never wraps.
- Latency with mem_ready=1 on the first request: BRANCH 3 cycles; R/I/LUI/AUIPC/JAL/JALR/S 4; LOAD 5.

Test Plan:
- ADD (opcode 0110011, f3 000, f7 0), mem_ready tied 1 -> states 0,1,2,4,0; ALU_C=0000; reg_write and pc_write high only in WB; retired=1.
- LOAD with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, mem_we=0; WB has mem_reg=1, imm_sel=10; total 8 cycles; retired=1.
- BRANCH, branch_taken=1 then a second branch with 0 -> next_sel 11 then 00 at EXEC; 3 cycles each; reg_write never asserted.
- opcode 1111111, then separately R f3=010 f7=1 (STRICT_F7=1) -> TRAP, illegal=1, all strobes 0, holds until rst_n pulse.
- mem_ready held 0 in FETCH, TIMEOUT_W=4 -> TRAP after 15 cycles, timeout_err=1.
- rst_n low mid-MEM of a store -> same-edge mem_req=0 and mem_we=0, state=0, retired=0; SRAI (I, f3 101, f7 1) after release -> ALU_C=1001.
